uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Wishbone master that shares the single UART transmitter slave among NUM_REQ byte-stream requesters using round-robin arbitration.
- Each accepted byte becomes one Wishbone write cycle to the UART.
- After each write, the block enforces a character-time gap so that no write arrives while the UART is still shifting the previous byte. The UART exposes no busy flag.
- Sits between CPU/debug byte sources and the UART slave port on the system bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DAT_WIDTH, 64, Wishbone data width (matches system `DAT_WIDTH)
CHAR_GAP, 10416, clk_i cycles waited after each ack before the next grant (12 bit times at 115200 baud, 100 MHz)
ACK_TIMEOUT, 16, cycles stb may stay high without ack/err before the write is abandoned

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-low
req_valid_i  in  NUM_REQ  requester i has a byte pending
req_data_i  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
req_ready_o  out  NUM_REQ  byte of requester i accepted this cycle (valid&ready)
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable (always 1 while stb)
wb_dat_o  out  DAT_WIDTH  {zeros, byte}
wb_ack_i  in  1  slave ack
wb_err_i  in  1  slave error
grant_o  out  NUM_REQ  one-hot owner of the byte in flight; 0 when none
busy_o  out  1  state != IDLE
err_count_o  out  8  saturating count of err and timeout events

Behaviour:
- Reset (rst_i low at posedge): state=IDLE; cyc/stb/we=0; wb_dat_o=0; grant_o=0; req_ready_o=0; err_count_o=0; gap and timeout counters=0; RR pointer last=NUM_REQ-1, so requester 0 wins first.
- Reset mid-write: the cycle is dropped immediately and the byte is lost. There is no retry.
- IDLE:
  - Winner = first i with req_valid_i[i]=1, scanning from (last+1) mod NUM_REQ upward with wrap.
  - req_ready_o[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: latch the byte; last<=winner; grant_o<=onehot(winner); go to WRITE.
  - No valid: stay in IDLE with all ready bits 0.
- WRITE:
  - cyc=stb=we=1; wb_dat_o={DAT_WIDTH-8 zeros, byte}; timeout counter increments each cycle.
  - ack_i=1: drop cyc/stb next edge; load gap counter=CHAR_GAP-1; go to GAP.
  - err_i=1 (takes priority over a simultaneous ack): byte dropped; err_count_o+1, saturating at 255; go to GAP.
  - Timeout counter reaches ACK_TIMEOUT-1 with no ack/err: byte dropped; err_count_o+1, saturating; go to IDLE directly with no gap.
  - Typical latency against the UART: accept at T, stb at T+1, ack seen at T+1 or T+2, stb low the following cycle.
- GAP:
  - cyc/stb=0; grant_o holds the last owner; all ready bits 0.
  - Counter decrements each cycle; at 0, grant_o<=0 and go to IDLE.
  - Next acceptance can occur no sooner than CHAR_GAP cycles after the ack cycle.
- Fairness:
  - A requester holding valid continuously cannot win twice in a row if any other requester is valid at the IDLE decision.
  - Worst-case wait: NUM_REQ-1 grants.
- Invariants:
  - At most one req_ready_o bit is high, and only in IDLE.
  - wb_stb_o implies wb_cyc_o and wb_we_o.
  - wb_dat_o is stable for the whole WRITE state.

Test Plan (bench overrides CHAR_GAP=20, ACK_TIMEOUT=8; slave model acks one cycle after stb unless stated):
- Reset with rst_i=0 for 3 cycles → all outputs 0. Release, then req_valid_i=4'b0001, data0=8'h41 → ready_o=0001 same cycle; stb high next cycle with wb_dat_o=64'h41; ack; stb low; grant_o=0001 for 20 gap cycles, then 0.
- All four requesters valid continuously, bytes 'A','B','C','D' → grant order 0,1,2,3,0,1; consecutive stb rising edges are ≥22 cycles apart.
- Only requesters 1 and 3 valid after a grant to 3 → next grant 1, then 3; requesters 0 and 2 are never granted.
- Slave asserts ack and err together on a write of 8'h55 → err_count_o=1; state enters GAP; byte not retried.
- Slave never acks → stb stays high 8 cycles, then drops; err_count_o increments; next requester is granted on the following IDLE cycle with no gap.
- rst_i pulled low while stb=1 → cyc/stb/grant_o low at the next edge. After release, requester 0 has priority again.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin Wishbone write master that funnels NUM_REQ byte streams into one UART.
// After every write it holds off for a character time, since the UART has no busy flag.
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DAT_WIDTH   = 64,
  parameter int CHAR_GAP    = 10416,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [DAT_WIDTH-1:0]   wb_dat_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic [7:0]             err_count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]         state_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [IDX_W:0]     scan_idx;
  logic [7:0]         win_byte;
  logic [7:0]         byte_q;
  logic [GAP_W-1:0]   gap_q;
  logic [TO_W-1:0]    to_q;
  logic [7:0]         err_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               accept;

  // Round-robin scan starting just after the last owner, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = {1'b0, last_q} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid_i[scan_idx[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_byte = req_data_i[8*i +: 8];
      end
    end
  end

  // Handshake: byte i transfers on a rising edge where req_valid_i[i] and req_ready_o[i]
  // are both high. Ready is offered only in IDLE and only to the round-robin winner;
  // a requester may hold valid across any number of cycles until it is served.
  assign accept = rst_i && (state_q == ST_IDLE) && win_found;

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NUM_REQ-1);
      byte_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      err_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            byte_q  <= win_byte;
            last_q  <= win_idx;
            grant_q <= req_ready_o;
            to_q    <= '0;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wb_err_i) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            gap_q   <= GAP_W'(CHAR_GAP-1);
            state_q <= ST_GAP;
          end else if (wb_ack_i) begin
            gap_q   <= GAP_W'(CHAR_GAP-1);
            state_q <= ST_GAP;
          end else if (to_q == TO_W'(ACK_TIMEOUT-1)) begin
            // Abandoned write: nothing was shifted out, so no character gap is owed.
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_cyc_o    = (state_q == ST_WRITE);
  assign wb_stb_o    = (state_q == ST_WRITE);
  assign wb_we_o     = (state_q == ST_WRITE);
  assign wb_dat_o    = {{(DAT_WIDTH-8){1'b0}}, byte_q};
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_count_o = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration table plus hand-written
// sequences for the gap, ack+err, ack timeout and mid-write reset cases.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int DAT_WIDTH   = 64;
  localparam int CHAR_GAP    = 20;
  localparam int ACK_TIMEOUT = 8;
  localparam int MODE_ACK    = 0;
  localparam int MODE_ACKERR = 1;
  localparam int MODE_NOACK  = 2;
  localparam int NV          = 14;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [8*NUM_REQ-1:0]   req_data = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   wb_cyc, wb_stb, wb_we;
  logic [DAT_WIDTH-1:0]   wb_dat;
  logic                   wb_ack = 1'b0;
  logic                   wb_err = 1'b0;
  logic [NUM_REQ-1:0]     grant;
  logic                   busy;
  logic [7:0]             err_count;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int slave_mode = MODE_ACK;
  logic [DAT_WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] exp_ready;
    logic [7:0]         exp_byte;
  } vec_t;
  vec_t vecs[NV];

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .DAT_WIDTH(DAT_WIDTH),
    .CHAR_GAP(CHAR_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_dat_o(wb_dat),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .grant_o(grant), .busy_o(busy), .err_count_o(err_count)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // UART slave model: responds one cycle after it first sees stb.
  always @(posedge clk) begin
    if (!rst) begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (wb_stb && !wb_ack && !wb_err) begin
        if (slave_mode == MODE_ACK) wb_ack <= 1'b1;
        else if (slave_mode == MODE_ACKERR) begin
          wb_ack <= 1'b1;
          wb_err <= 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Holds rst low across three rising edges, leaving it low at a negedge.
  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    int prev_stb;
    int waited;
    int gap_ok;
    int hi;
    int stb_seen;
    logic [DAT_WIDTH-1:0] exp_dat;

    vecs[0]  = '{4'b1111, 4'b0001, 8'h41};
    vecs[1]  = '{4'b1111, 4'b0010, 8'h42};
    vecs[2]  = '{4'b1111, 4'b0100, 8'h43};
    vecs[3]  = '{4'b1111, 4'b1000, 8'h44};
    vecs[4]  = '{4'b1111, 4'b0001, 8'h41};
    vecs[5]  = '{4'b1111, 4'b0010, 8'h42};
    vecs[6]  = '{4'b1111, 4'b0100, 8'h43};
    vecs[7]  = '{4'b1111, 4'b1000, 8'h44};
    vecs[8]  = '{4'b1010, 4'b0010, 8'h42};
    vecs[9]  = '{4'b1010, 4'b1000, 8'h44};
    vecs[10] = '{4'b1010, 4'b0010, 8'h42};
    vecs[11] = '{4'b0100, 4'b0100, 8'h43};
    vecs[12] = '{4'b0011, 4'b0001, 8'h41};
    vecs[13] = '{4'b0011, 4'b0010, 8'h42};

    // Reset values and a single write with its full character gap
    hold_reset();
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_stb", wb_stb, 1'b0);
    chk("rst_we", wb_we, 1'b0);
    chk("rst_dat", wb_dat, 64'h0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errcnt", err_count, 8'h00);
    rst = 1'b1;
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    req_valid = 4'b0001;
    #1;
    chk("single_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("single_stb", {wb_cyc, wb_stb, wb_we}, 3'b111);
    chk("single_dat", wb_dat, 64'h41);
    chk("single_grant", grant, 4'b0001);
    @(negedge clk);
    chk("single_stb_ack_cycle", wb_stb, 1'b1);
    @(negedge clk);
    chk("single_stb_low", {wb_cyc, wb_stb}, 2'b00);
    gap_ok = 0;
    for (int k = 0; k < CHAR_GAP; k++) begin
      if (grant == 4'b0001 && busy) gap_ok++;
      @(negedge clk);
    end
    chk("single_gap_cycles", gap_ok, CHAR_GAP);
    chk("single_grant_clear", grant, 4'b0000);
    chk("single_idle", busy, 1'b0);

    // Table-driven round-robin with continuously valid requesters
    hold_reset();
    rst = 1'b1;
    prev_stb = 0;
    for (int i = 0; i < NV; i++) begin
      req_valid = vecs[i].valid;
      #1;
      waited = 0;
      while (req_ready == '0 && waited < 100) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk($sformatf("rr%0d_ready", i), req_ready, vecs[i].exp_ready);
      exp_q.push_back({56'h0, vecs[i].exp_byte});
      @(negedge clk);
      chk($sformatf("rr%0d_stb", i), wb_stb, 1'b1);
      chk($sformatf("rr%0d_grant", i), grant, vecs[i].exp_ready);
      exp_dat = exp_q.pop_front();
      chk($sformatf("rr%0d_dat", i), wb_dat, exp_dat);
      if (i > 0) chk($sformatf("rr%0d_stb_spacing", i), cyc_cnt - prev_stb, 23);
      prev_stb = cyc_cnt;
    end
    req_valid = 4'b0000;
    chk("rr_queue_empty", exp_q.size(), 0);
    wait_idle("rr_drain");

    // Simultaneous ack and err: counted as an error, gap still taken, no retry
    hold_reset();
    rst = 1'b1;
    slave_mode = MODE_ACKERR;
    req_data[7:0] = 8'h55;
    req_valid = 4'b0001;
    #1;
    chk("err_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("err_dat", wb_dat, 64'h55);
    @(negedge clk);
    @(negedge clk);
    chk("err_count", err_count, 8'd1);
    chk("err_in_gap", {busy, wb_stb}, 2'b10);
    chk("err_gap_grant", grant, 4'b0001);
    stb_seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (wb_stb) stb_seen++;
      @(negedge clk);
    end
    chk("err_no_retry", stb_seen, 0);
    chk("err_count_hold", err_count, 8'd1);
    slave_mode = MODE_ACK;

    // No ack: stb held ACK_TIMEOUT cycles, then straight back to IDLE
    hold_reset();
    rst = 1'b1;
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    slave_mode = MODE_NOACK;
    req_valid = 4'b0011;
    #1;
    chk("to_ready", req_ready, 4'b0001);
    @(negedge clk);
    hi = 0;
    while (wb_stb && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    chk("to_stb_cycles", hi, ACK_TIMEOUT);
    chk("to_errcnt", err_count, 8'd1);
    chk("to_grant_clear", grant, 4'b0000);
    chk("to_next_ready_no_gap", req_ready, 4'b0010);
    slave_mode = MODE_ACK;
    @(negedge clk);
    req_valid = 4'b0000;
    chk("to_next_grant", grant, 4'b0010);
    chk("to_next_dat", wb_dat, 64'h42);
    wait_idle("to_drain");

    // Reset during a write drops it and restores requester 0 priority
    req_valid = 4'b0100;
    #1;
    chk("mrst_ready", req_ready, 4'b0100);
    @(negedge clk);
    chk("mrst_stb", wb_stb, 1'b1);
    rst = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("mrst_bus_low", {wb_cyc, wb_stb}, 2'b00);
    chk("mrst_grant", grant, 4'b0000);
    chk("mrst_ready_in_reset", req_ready, 4'b0000);
    rst = 1'b1;
    #1;
    chk("mrst_prio0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("mrst_grant0", grant, 4'b0001);
    chk("mrst_dat0", wb_dat, 64'h41);
    wait_idle("mrst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
